// File: rtl/ram_loader.sv
// Program loader: streams bytes from a valid/ready source into a RAM, then
// reads the RAM back and compares additive checksums of written vs read data.
module ram_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prg_len,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              prg_mode,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] prg_data,
  output logic              wr_en,
  output logic              re_en,
  input  logic [DATA_W-1:0] bus_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        dbg_state
);

  // Source handshake: a byte moves on a rising edge where byte_valid and
  // byte_ready are both high; byte_ready is only ever high in LOAD.
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RADDR, RSAMPLE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  state_t              state_q;
  logic [ADDR_W-1:0]   last_q;
  logic [ADDR_W-1:0]   address_q;
  logic [DATA_W-1:0]   prg_data_q;
  logic [DATA_W-1:0]   wsum_q;
  logic [DATA_W-1:0]   rsum_q;
  logic [3:0]          wcnt_q;
  logic                byte_ready_q;
  logic                prg_mode_q;
  logic                wr_en_q;
  logic                re_en_q;
  logic                done_q;
  logic                pass_q;
  logic [ADDR_W-1:0]   last_d;

  // Zero or oversized lengths load the whole RAM.
  always_comb begin
    last_d = '1;
    if (prg_len != '0 && prg_len <= DEPTH) last_d = ADDR_W'(prg_len - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= '0;
      address_q    <= '0;
      prg_data_q   <= '0;
      wsum_q       <= '0;
      rsum_q       <= '0;
      wcnt_q       <= '0;
      byte_ready_q <= 1'b0;
      prg_mode_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      re_en_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else if (abort) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      byte_ready_q <= 1'b0;
      prg_mode_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      re_en_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q      <= LOAD;
            last_q       <= last_d;
            address_q    <= '0;
            wsum_q       <= '0;
            rsum_q       <= '0;
            pass_q       <= 1'b0;
            prg_mode_q   <= 1'b1;
            byte_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (byte_valid && byte_ready_q) begin
            prg_data_q   <= byte_in;
            wsum_q       <= wsum_q + byte_in;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b1;
            wcnt_q       <= '0;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (wcnt_q == 4'(WR_CYCLES - 1)) begin
            wr_en_q <= 1'b0;
            if (address_q == last_q) begin
              // Read enable rises as write enable falls, so they never overlap.
              address_q  <= '0;
              prg_mode_q <= 1'b0;
              re_en_q    <= 1'b1;
              state_q    <= RADDR;
            end else begin
              address_q    <= address_q + 1'b1;
              byte_ready_q <= 1'b1;
              state_q      <= LOAD;
            end
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        RADDR: state_q <= RSAMPLE;
        RSAMPLE: begin
          rsum_q <= rsum_q + bus_in;
          if (address_q == last_q) begin
            re_en_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            address_q <= address_q + 1'b1;
            state_q   <= RADDR;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          pass_q  <= (rsum_q == wsum_q);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign prg_mode   = prg_mode_q;
  assign address    = address_q;
  assign prg_data   = prg_data_q;
  assign wr_en      = wr_en_q;
  assign re_en      = re_en_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign pass       = pass_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width (16 locations).
REQ-002 Parameter DATA_W, default 8, RAM and bus data width.
REQ-003 Parameter WR_CYCLES, default 1, number of clocks wr_en is held per write (range 1..8).
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  begin load sequence; sampled only in IDLE.
REQ-007 Port abort  input  1  terminate any sequence; return to IDLE next cycle.
REQ-008 Port prg_len  input  ADDR_W+1  byte count to load; value 0 or >16 treated as 16.
REQ-009 Port byte_in  input  DATA_W  program byte from source.
REQ-010 Port byte_valid  input  1  byte_in holds a valid byte.
REQ-011 Port byte_ready  output  1  loader accepts byte this cycle.
REQ-012 Port prg_mode  output  1  selects prg_data as RAM write source.
REQ-013 Port address  output  ADDR_W  RAM address.
REQ-014 Port prg_data  output  DATA_W  RAM write data.
REQ-015 Port wr_en  output  1  RAM write enable.
REQ-016 Port re_en  output  1  RAM read enable (RAM drives bus).
REQ-017 Port bus_in  input  DATA_W  RAM bus value during readback.
REQ-018 Port busy  output  1  high in every state except IDLE.
REQ-019 Port done  output  1  one-cycle pulse at sequence completion.
REQ-020 Port pass  output  1  readback checksum matched; held until next start, abort or reset.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, WRITE, RADDR, RSAMPLE, DONE.
REQ-022 IDLE: start=1 -> LOAD; latch len, address=0, wsum=0, rsum=0, pass=0, prg_mode=1.
REQ-023 LOAD: byte_ready=1; transfer occurs only when byte_valid && byte_ready; on transfer prg_data<=byte_in, wsum<=wsum+byte_in (mod 2^DATA_W), -> WRITE.
REQ-024 LOAD with byte_valid=0 SHALL wait indefinitely, all outputs stable.
REQ-025 WRITE: wr_en=1 for exactly WR_CYCLES consecutive clocks with address and prg_data stable; byte_ready=0.
REQ-026 After WRITE: if address==len-1 -> RADDR with address=0 and prg_mode=0; else address+1 -> LOAD.
REQ-027 RADDR: re_en=1, one cycle, -> RSAMPLE.
REQ-028 RSAMPLE: re_en=1, rsum<=rsum+bus_in (mod 2^DATA_W); if address==len-1 -> DONE else address+1 -> RADDR.
REQ-029 DONE: done=1 for one cycle, pass<=(rsum==wsum), -> IDLE.
REQ-030 wr_en and re_en SHALL never be high in the same cycle.
REQ-031 wr_en, re_en, byte_ready SHALL be low in IDLE and DONE.
REQ-032 start while busy SHALL be ignored.
REQ-033 abort has priority over all transitions except rst; next cycle IDLE, wr_en/re_en/prg_mode/byte_ready=0, pass=0, no done pulse.
REQ-034 start and abort both high in IDLE: abort wins, remain IDLE.
REQ-035 len=16: address SHALL reach 15 and terminate without wrapping to 0 within a phase.
REQ-036 Per-byte write latency: handshake cycle to wr_en rise = 1 clock.

Reset
REQ-037 rst=1 SHALL force IDLE on next edge regardless of state.
REQ-038 Reset values: byte_ready=0, prg_mode=0, address=0, prg_data=0, wr_en=0, re_en=0, busy=0, done=0, pass=0, wsum=0, rsum=0.
REQ-039 Reset mid-WRITE SHALL drop wr_en the following cycle; no further RAM access.

Verification
REQ-040 prg_len=4, bytes 0x00,0x0C,0x18,0x24, RAM model echoes -> 4 writes at addr 0..3, 4 reads, done pulse, pass=1.
REQ-041 Same load, model corrupts addr 2 to 0x19 -> done pulse, pass=0.
REQ-042 prg_len=0, 16 bytes i*3 -> writes at addr 0..15, last address 15, no wrap, pass=1.
REQ-043 WR_CYCLES=3, byte_valid toggling every other cycle -> wr_en high exactly 3 clocks per byte, byte_ready low during WRITE.
REQ-044 abort during third WRITE -> next cycle busy=0, wr_en=0, pass=0, no done; later start runs cleanly.
REQ-045 rst asserted in RSAMPLE -> all outputs at reset values next cycle; start ignored while busy checked in same run.
